// File: rtl/game_sequencer.sv
// PacMan game sequencer: builds dot maps, scores eaten dots and ghosts,
// detects collisions and steps through ready/playing/dying/win/game-over.
module game_sequencer #(
    parameter int TILE_SIZE    = 20,
    parameter int COLL_DIST    = 12,
    parameter int READY_TICKS  = 200,
    parameter int DEATH_TICKS  = 150,
    parameter int WIN_TICKS    = 300,
    parameter int FRIGHT_TICKS = 600
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic [767:0] tilemap_walls,
    input  logic [9:0]   player_x,
    input  logic [8:0]   player_y,
    input  logic [9:0]   ghost1_x,
    input  logic [8:0]   ghost1_y,
    input  logic [9:0]   ghost2_x,
    input  logic [8:0]   ghost2_y,
    input  logic [9:0]   ghost3_x,
    input  logic [8:0]   ghost3_y,
    input  logic [9:0]   ghost4_x,
    input  logic [8:0]   ghost4_y,
    output logic [2:0]   game_state,
    output logic [767:0] tilemap_dots,
    output logic [767:0] tilemap_big_dots,
    output logic [15:0]  score,
    output logic [1:0]   lives,
    output logic         frightened,
    output logic [3:0]   ghost_eaten,
    output logic         chars_reset,
    output logic [9:0]   dots_remaining
);

    typedef enum logic [2:0] {
        S_INIT, S_READY, S_PLAY, S_DYING, S_WIN, S_OVER
    } state_t;

    state_t       state_q, state_d;
    logic [767:0] dots_q, dots_d;
    logic [767:0] big_q, big_d;
    logic [15:0]  score_q, score_d;
    logic [1:0]   lives_q, lives_d;
    logic [9:0]   rem_q, rem_d;
    logic [9:0]   timer_q, timer_d;
    logic [9:0]   fright_q, fright_d;
    logic [3:0]   eaten_q, eaten_d;
    logic         chars_q, chars_d;
    logic [9:0]   idx_q, idx_d;

    logic [10:0] cx;
    logic [9:0]  cy;
    logic [10:0] col;
    logic [9:0]  row;
    logic        on_grid;
    logic [9:0]  tile;
    logic [9:0]  gx [4];
    logic [8:0]  gy [4];
    logic [9:0]  dx [4];
    logic [8:0]  dy [4];
    logic [3:0]  hit;
    logic        scan_big;

    assign cx      = {1'b0, player_x} + 11'(TILE_SIZE / 2);
    assign cy      = {1'b0, player_y} + 10'(TILE_SIZE / 2);
    assign col     = 11'(32'(cx) / TILE_SIZE);
    assign row     = 10'(32'(cy) / TILE_SIZE);
    assign on_grid = (row < 10'd24) && (col < 11'd32);
    assign tile    = {row[4:0], col[4:0]};

    assign gx[0] = ghost1_x;
    assign gx[1] = ghost2_x;
    assign gx[2] = ghost3_x;
    assign gx[3] = ghost4_x;
    assign gy[0] = ghost1_y;
    assign gy[1] = ghost2_y;
    assign gy[2] = ghost3_y;
    assign gy[3] = ghost4_y;

    assign scan_big = (idx_q == 10'd33)  || (idx_q == 10'd62) ||
                      (idx_q == 10'd705) || (idx_q == 10'd734);

    // Per-ghost bounding-box collision against the player
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            dx[g]  = (gx[g] >= player_x) ? gx[g] - player_x
                                         : player_x - gx[g];
            dy[g]  = (gy[g] >= player_y) ? gy[g] - player_y
                                         : player_y - gy[g];
            hit[g] = (dx[g] < 10'(COLL_DIST)) &&
                     (dy[g] < 9'(COLL_DIST));
        end
    end

    // Phase sequencing, map scan and scoring
    always_comb begin
        logic [17:0] add;
        logic [17:0] sum;
        logic        fr_act;
        logic        die;
        logic        ate_big;

        state_d  = state_q;
        dots_d   = dots_q;
        big_d    = big_q;
        lives_d  = lives_q;
        rem_d    = rem_q;
        timer_d  = timer_q;
        fright_d = fright_q;
        eaten_d  = '0;
        chars_d  = chars_q;
        idx_d    = idx_q;
        add      = '0;
        fr_act   = 1'b0;
        die      = 1'b0;
        ate_big  = 1'b0;

        unique case (state_q)
            S_INIT: begin
                chars_d       = 1'b1;
                dots_d[idx_q] = !tilemap_walls[idx_q] && !scan_big;
                big_d[idx_q]  = !tilemap_walls[idx_q] && scan_big;
                if (!tilemap_walls[idx_q]) begin
                    rem_d = rem_q + 10'd1;
                end
                if (idx_q == 10'd767) begin
                    idx_d   = '0;
                    state_d = S_READY;
                    timer_d = 10'(READY_TICKS);
                end else begin
                    idx_d = idx_q + 10'd1;
                end
            end
            S_READY: begin
                if (tick) begin
                    if (timer_q <= 10'd1) begin
                        timer_d = '0;
                        state_d = S_PLAY;
                        chars_d = 1'b0;
                    end else begin
                        timer_d = timer_q - 10'd1;
                    end
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (fright_q != '0) begin
                        fright_d = fright_q - 10'd1;
                    end
                    if (on_grid && dots_q[tile]) begin
                        dots_d[tile] = 1'b0;
                        add          = add + 18'd10;
                        rem_d        = rem_q - 10'd1;
                    end else if (on_grid && big_q[tile]) begin
                        big_d[tile] = 1'b0;
                        add         = add + 18'd50;
                        rem_d       = rem_q - 10'd1;
                        ate_big     = 1'b1;
                        fright_d    = 10'(FRIGHT_TICKS);
                    end
                    fr_act = (fright_q != '0) || ate_big;
                    if (fr_act) begin
                        eaten_d = hit;
                        for (int g = 0; g < 4; g++) begin
                            if (hit[g]) add = add + 18'd200;
                        end
                    end else begin
                        die = |hit;
                    end
                    if (rem_d == '0) begin
                        state_d  = S_WIN;
                        timer_d  = 10'(WIN_TICKS);
                        fright_d = '0;
                    end else if (die) begin
                        state_d  = S_DYING;
                        lives_d  = lives_q - 2'd1;
                        timer_d  = 10'(DEATH_TICKS);
                        fright_d = '0;
                    end
                end
            end
            S_DYING: begin
                chars_d = 1'b0;
                if (tick) begin
                    if (timer_q <= 10'd1) begin
                        chars_d = 1'b1;
                        if (lives_q == 2'd0) begin
                            timer_d = '0;
                            state_d = S_OVER;
                        end else begin
                            timer_d = 10'(READY_TICKS);
                            state_d = S_READY;
                        end
                    end else begin
                        timer_d = timer_q - 10'd1;
                    end
                end
            end
            S_WIN: begin
                if (tick) begin
                    if (timer_q <= 10'd1) begin
                        timer_d = '0;
                        idx_d   = '0;
                        chars_d = 1'b1;
                        state_d = S_INIT;
                    end else begin
                        timer_d = timer_q - 10'd1;
                    end
                end
            end
            S_OVER: begin
                chars_d = 1'b1;
            end
            default: begin
                state_d = S_INIT;
                idx_d   = '0;
                chars_d = 1'b1;
            end
        endcase

        sum     = {2'b00, score_q} + add;
        score_d = (sum > 18'd65535) ? 16'hFFFF : sum[15:0];
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_INIT;
            dots_q   <= '0;
            big_q    <= '0;
            score_q  <= '0;
            lives_q  <= 2'd3;
            rem_q    <= '0;
            timer_q  <= '0;
            fright_q <= '0;
            eaten_q  <= '0;
            chars_q  <= 1'b1;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            dots_q   <= dots_d;
            big_q    <= big_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            rem_q    <= rem_d;
            timer_q  <= timer_d;
            fright_q <= fright_d;
            eaten_q  <= eaten_d;
            chars_q  <= chars_d;
            idx_q    <= idx_d;
        end
    end

    // External phase code; INIT is reported as READY
    always_comb begin
        game_state = 3'd0;
        unique case (state_q)
            S_INIT:  game_state = 3'd0;
            S_READY: game_state = 3'd0;
            S_PLAY:  game_state = 3'd1;
            S_DYING: game_state = 3'd2;
            S_WIN:   game_state = 3'd3;
            S_OVER:  game_state = 3'd4;
            default: game_state = 3'd0;
        endcase
    end

    assign tilemap_dots     = dots_q;
    assign tilemap_big_dots = big_q;
    assign score            = score_q;
    assign lives            = lives_q;
    assign frightened       = (fright_q != '0);
    assign ghost_eaten      = eaten_q;
    assign chars_reset      = chars_q;
    assign dots_remaining   = rem_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed phase walk-through plus random
// player/ghost movement checked against a rule-level game model.
module tb_game_sequencer;

    localparam int P_READY = 0;
    localparam int P_PLAY  = 1;
    localparam int P_DYING = 2;
    localparam int P_WIN   = 3;
    localparam int P_OVER  = 4;
    localparam int P_INIT  = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick = 1'b0;
    logic [767:0] walls = '0;
    logic [9:0]   px = '0;
    logic [8:0]   py = '0;
    logic [9:0]   gx [4];
    logic [8:0]   gy [4];
    logic [2:0]   game_state;
    logic [767:0] tilemap_dots;
    logic [767:0] tilemap_big_dots;
    logic [15:0]  score;
    logic [1:0]   lives;
    logic         frightened;
    logic [3:0]   ghost_eaten;
    logic         chars_reset;
    logic [9:0]   dots_remaining;

    int errors = 0;
    int checks = 0;

    bit [767:0] m_dots, m_big;
    int  m_score, m_lives, m_rem, m_fr, m_phase, m_timer;
    bit  m_chars;
    bit  [3:0] m_eaten;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick),
        .tilemap_walls(walls),
        .player_x(px), .player_y(py),
        .ghost1_x(gx[0]), .ghost1_y(gy[0]),
        .ghost2_x(gx[1]), .ghost2_y(gy[1]),
        .ghost3_x(gx[2]), .ghost3_y(gy[2]),
        .ghost4_x(gx[3]), .ghost4_y(gy[3]),
        .game_state(game_state),
        .tilemap_dots(tilemap_dots),
        .tilemap_big_dots(tilemap_big_dots),
        .score(score), .lives(lives),
        .frightened(frightened),
        .ghost_eaten(ghost_eaten),
        .chars_reset(chars_reset),
        .dots_remaining(dots_remaining)
    );

    task automatic chk(input string tag, input logic [767:0] obs,
                       input logic [767:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_open(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (!walls[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        m_dots = '0; m_big = '0; m_score = 0; m_lives = 3;
        m_rem = 0; m_fr = 0; m_phase = P_INIT; m_timer = 0;
        m_chars = 1; m_eaten = '0;
    endtask

    task automatic model_scan();
        m_dots = '0; m_big = '0;
        for (int i = 0; i < 768; i++) begin
            if (!walls[i]) begin
                if (i == 33 || i == 62 || i == 705 || i == 734) m_big[i] = 1;
                else m_dots[i] = 1;
                m_rem++;
            end
        end
        m_phase = P_READY; m_timer = 200; m_chars = 1;
    endtask

    task automatic model_tick();
        int col, row, i, gain, ddx, ddy;
        bit fr_act, die, ate_big;
        m_eaten = '0;
        case (m_phase)
            P_READY: begin
                m_timer--;
                if (m_timer == 0) begin m_phase = P_PLAY; m_chars = 0; end
            end
            P_PLAY: begin
                col = (int'(px) + 10) / 20;
                row = (int'(py) + 10) / 20;
                gain = 0; ate_big = 0; die = 0;
                if (row < 24 && col < 32) begin
                    i = row * 32 + col;
                    if (m_dots[i]) begin
                        m_dots[i] = 0; gain += 10; m_rem--;
                    end else if (m_big[i]) begin
                        m_big[i] = 0; gain += 50; m_rem--; ate_big = 1;
                    end
                end
                fr_act = (m_fr > 0) || ate_big;
                if (ate_big) m_fr = 600;
                else if (m_fr > 0) m_fr--;
                for (int g = 0; g < 4; g++) begin
                    ddx = int'(gx[g]) - int'(px);
                    ddy = int'(gy[g]) - int'(py);
                    if (ddx < 0) ddx = -ddx;
                    if (ddy < 0) ddy = -ddy;
                    if (ddx < 12 && ddy < 12) begin
                        if (fr_act) begin m_eaten[g] = 1; gain += 200; end
                        else die = 1;
                    end
                end
                m_score = (m_score + gain > 65535) ? 65535 : m_score + gain;
                if (m_rem == 0) begin
                    m_phase = P_WIN; m_timer = 300; m_fr = 0;
                end else if (die) begin
                    m_phase = P_DYING; m_lives--; m_timer = 150; m_fr = 0;
                end
            end
            P_DYING: begin
                m_timer--;
                if (m_timer == 0) begin
                    m_chars = 1;
                    if (m_lives == 0) m_phase = P_OVER;
                    else begin m_phase = P_READY; m_timer = 200; end
                end
            end
            P_WIN: begin
                m_timer--;
                if (m_timer == 0) begin m_phase = P_INIT; m_chars = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        chk("game_state", game_state, (m_phase == P_INIT) ? 0 : m_phase);
        chk("score", score, m_score);
        chk("lives", lives, m_lives);
        chk("dots_remaining", dots_remaining, m_rem);
        chk("frightened", frightened, m_fr > 0);
        chk("ghost_eaten", ghost_eaten, m_eaten);
        chk("chars_reset", chars_reset, m_chars);
    endtask

    task automatic compare_maps();
        chk("dots_map", tilemap_dots, m_dots);
        chk("big_map", tilemap_big_dots, m_big);
    endtask

    task automatic step(input bit t);
        tick = t;
        if (t) model_tick();
        else m_eaten = '0;
        @(posedge clk);
        #1;
        tick = 0;
        compare_all();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, game_state, 0);
        chk({tag, "_dots"}, tilemap_dots, 0);
        chk({tag, "_big"}, tilemap_big_dots, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_lives"}, lives, 3);
        chk({tag, "_rem"}, dots_remaining, 0);
        chk({tag, "_fright"}, frightened, 0);
        chk({tag, "_eaten"}, ghost_eaten, 0);
        chk({tag, "_chars"}, chars_reset, 1);
    endtask

    task automatic do_reset(input string tag);
        tick = 0;
        #3 reset = 1;
        #1;
        model_reset();
        chk_reset_vals(tag);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic run_init();
        repeat (767) begin @(posedge clk); #1; end
        chk("init_rem_767", dots_remaining, count_open(767));
        chk("init_chars", chars_reset, 1);
        @(posedge clk);
        #1;
        model_scan();
        compare_all();
        compare_maps();
    endtask

    task automatic ghosts_far();
        for (int g = 0; g < 4; g++) begin gx[g] = 10'd1000; gy[g] = 9'd500; end
    endtask

    task automatic ghosts_on_player(input int n);
        for (int g = 0; g < n; g++) begin gx[g] = px; gy[g] = py; end
    endtask

    initial begin
        int guard, v;
        bit seen_death;
        ghosts_far();

        // power-on reset and first scan over an open board
        do_reset("rst0");
        run_init();
        chk("big_33", tilemap_big_dots[33], 1);
        chk("big_62", tilemap_big_dots[62], 1);
        chk("big_705", tilemap_big_dots[705], 1);
        chk("big_734", tilemap_big_dots[734], 1);
        chk("rem_768", dots_remaining, 768);
        repeat (199) step(1);
        chk("ready_199", game_state, 0);
        step(1);
        chk("play_state", game_state, 1);
        chk("play_chars", chars_reset, 0);

        // eat big dot at tile (1,1)
        px = 10'd20; py = 9'd20;
        step(1);
        chk("big33_clr", tilemap_big_dots[33], 0);
        chk("score_50", score, 50);
        chk("fright_on", frightened, 1);
        compare_maps();

        // ghost1 eaten while frightened, pulse lasts one clk
        gx[0] = 10'd25; gy[0] = 9'd20;
        step(1);
        chk("eaten_g1", ghost_eaten, 4'b0001);
        chk("score_250", score, 250);
        step(0);
        chk("eaten_clr", ghost_eaten, 0);
        ghosts_far();

        // frightened runs 600 ticks from the big dot
        repeat (598) step(1);
        chk("fright_last", frightened, 1);
        step(1);
        chk("fright_off", frightened, 0);

        // tile-edge boundaries
        px = 10'd629; py = 9'd20;
        step(1);
        chk("col31_rem", dots_remaining, 766);
        chk("col31_score", score, 260);
        px = 10'd630;
        step(1);
        chk("col32_rem", dots_remaining, 766);
        px = 10'd20; py = 9'd470;
        step(1);
        chk("row24_rem", dots_remaining, 766);
        py = 9'd469;
        step(1);
        chk("row23_rem", dots_remaining, 765);
        chk("row23_score", score, 270);
        compare_maps();

        // reset mid-PLAYING, then mid-INIT
        do_reset("rst_play");
        repeat (300) begin @(posedge clk); #1; end
        chk("scan_300", dots_remaining, 300);
        do_reset("rst_init");
        run_init();
        chk("rescan_768", dots_remaining, 768);
        repeat (200) step(1);

        // random roaming, ghosts out of reach
        repeat (300) begin
            px = 10'($urandom_range(660));
            py = 9'($urandom_range(511));
            step(1);
        end
        compare_maps();

        // random roaming with ghosts sometimes close
        repeat (300) begin
            px = 10'($urandom_range(660));
            py = 9'($urandom_range(511));
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(7) == 0) begin
                    v = int'(px) + int'($urandom_range(30)) - 15;
                    if (v < 0) v = 0;
                    if (v > 1023) v = 1023;
                    gx[g] = 10'(v);
                    v = int'(py) + int'($urandom_range(30)) - 15;
                    if (v < 0) v = 0;
                    if (v > 511) v = 511;
                    gy[g] = 9'(v);
                end else begin
                    gx[g] = 10'd1000; gy[g] = 9'd500;
                end
            end
            step(1);
        end
        compare_maps();

        // score saturation with four ghosts eaten every tick
        walls = '0;
        ghosts_far();
        do_reset("rst_sat");
        run_init();
        repeat (200) step(1);
        px = 10'd20; py = 9'd20;
        ghosts_on_player(4);
        step(1);
        chk("sat_first", score, 850);
        chk("sat_eaten", ghost_eaten, 4'b1111);
        repeat (89) step(1);
        chk("sat_score", score, 16'hFFFF);

        // deaths until game over
        guard = 0;
        seen_death = 0;
        while (m_phase != P_OVER && guard < 5000) begin
            if (m_phase == P_PLAY) ghosts_on_player(1);
            else ghosts_far();
            step(1);
            if (m_phase == P_DYING && !seen_death) begin
                seen_death = 1;
                chk("death1_lives", lives, 2);
                chk("death1_state", game_state, 2);
            end
            guard++;
        end
        chk("over_state", game_state, 4);
        chk("over_lives", lives, 0);
        chk("over_chars", chars_reset, 1);
        repeat (20) step(1);
        chk("over_hold", game_state, 4);

        // single-dot board: eat and collide on the same tick
        walls = '1;
        walls[40] = 1'b0;
        ghosts_far();
        do_reset("rst_one");
        run_init();
        chk("one_rem", dots_remaining, 1);
        chk("one_dot40", tilemap_dots[40], 1);
        repeat (200) step(1);
        px = 10'd160; py = 9'd20;
        ghosts_on_player(1);
        step(1);
        chk("win_state", game_state, 3);
        chk("win_lives", lives, 3);
        chk("win_score", score, 10);
        repeat (299) step(1);
        chk("win_hold", game_state, 3);
        step(1);
        chk("win_to_init", game_state, 0);
        chk("win_init_chars", chars_reset, 1);
        chk("win_keep_score", score, 10);
        run_init();
        chk("reinit_rem", dots_remaining, 1);
        chk("reinit_score", score, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game controller for PacMan. It owns the dot and big-dot tilemaps and scores dots eaten by the player. It detects player/ghost collisions and sequences the game through the ready, playing, dying, level-clear and game-over phases. It drives game_state and the dot maps into the Renderer, and drives chars_reset and ghost_eaten into the player and ghost controllers.

Parameters:
TILE_SIZE, 20, tile edge in pixels (grid is 32 cols x 24 rows, index = row*32+col)
COLL_DIST, 12, pixel distance on each axis below which a player/ghost collision is declared
READY_TICKS, 200, ticks spent in READY before PLAYING
DEATH_TICKS, 150, ticks spent in DYING
WIN_TICKS, 300, ticks spent in WIN before the next level
FRIGHT_TICKS, 600, frightened duration in ticks after a big dot

Ports:
clk  in  1  system clock (25 MHz domain)
reset  in  1  asynchronous, active-high reset
tick  in  1  single-clk game-step enable at 100 Hz
tilemap_walls  in  768  wall map, bit=1 means wall
player_x  in  10  player sprite top-left x, in pixels
player_y  in  9  player sprite top-left y, in pixels
ghostN_x / ghostN_y  in  10 / 9  ghost N top-left position, for N=1..4
game_state  out  3  READY=0, PLAYING=1, DYING=2, WIN=3, GAME_OVER=4
tilemap_dots  out  768  small-dot map
tilemap_big_dots  out  768  big-dot map
score  out  16  binary score, saturating at 65535
lives  out  2  remaining lives
frightened  out  1  high while the frightened timer is non-zero
ghost_eaten  out  4  one-clk pulse per eaten ghost, bit N-1 = ghost N
chars_reset  out  1  high while characters must be held at their spawn points
dots_remaining  out  10  count of small plus big dots left

Behaviour:
- Internal FSM states are INIT, READY, PLAYING, DYING, WIN, GAME_OVER. INIT reports game_state=READY.
- Reset (asynchronous):
  - state=INIT, both dot maps=0, score=0, lives=3, dots_remaining=0.
  - Timers=0, frightened=0, ghost_eaten=0, chars_reset=1, scan index=0.
- INIT (one tile per clk, ignores tick):
  - For idx 0..767: if the wall bit is 0, set a big dot at (1,1), (1,30), (22,1) or (22,30); otherwise set a small dot. dots_remaining increments for each dot set.
  - Exit after idx 767: to READY, timer=READY_TICKS. Total 768 clks.
  - chars_reset=1 throughout INIT and READY.
- READY: decrement the timer on tick. When the timer hits 0, go to PLAYING and drop chars_reset.
- PLAYING, evaluated only on a tick clk, all updates registered that clk:
  - Player tile: col=(player_x+TILE_SIZE/2)/TILE_SIZE, row=(player_y+TILE_SIZE/2)/TILE_SIZE, exact floor division. Row ≥24 or col ≥32 means no eat.
  - Small dot at the tile: clear it, score+=10, dots_remaining−=1.
  - Big dot at the tile: clear it, score+=50, dots_remaining−=1, frightened timer=FRIGHT_TICKS.
  - Collision per ghost: |gx−px|<COLL_DIST and |gy−py|<COLL_DIST.
  - Collision while frightened (including a frightened timer set by this same tick): ghost_eaten bit pulses for 1 clk and score+=200 per ghost. Multiple ghosts the same tick are summed.
  - Collision while not frightened: to DYING, lives−=1, timer=DEATH_TICKS.
  - dots_remaining reaching 0: to WIN, timer=WIN_TICKS. This takes priority over a death on the same tick.
  - The frightened timer decrements on each tick. It is frozen outside PLAYING and cleared on entering DYING or WIN.
- DYING: chars_reset=0. When the timer expires, go to GAME_OVER if lives==0; otherwise go to READY with timer=READY_TICKS and chars_reset=1. Dot maps are kept.
- WIN: when the timer expires, go to INIT and set chars_reset=1. Score and lives are kept; the scan re-initialises the maps.
- GAME_OVER: terminal, held until reset. chars_reset=1.
- Score adds saturate at 65535. A tick arriving in the same clk as a reset deassertion edge is ignored.

Test Plan:
- Reset, then all-zero walls: after 768 clks dots_remaining=768, big-dot bits set at idx 33, 62, 705 and 734, game_state=0. After 200 ticks game_state=1 and chars_reset=0.
- Player at (20,20) over the big dot at tile (1,1), one tick: bit 33 cleared, score=50, frightened=1. frightened drops after 600 ticks.
- Ghost1 at (25,20) during frightened: ghost_eaten=4'b0001 for 1 clk, score +200. Same stimulus when not frightened: game_state=2, lives=2.
- Three deaths: after the third DEATH_TICKS expires, game_state=4 and stays 4 under further ticks until reset.
- Walls all 1 except tile 40: after INIT dots_remaining=1. Eating the dot while a ghost collides the same tick gives game_state=3 and lives unchanged. After 300 ticks the block re-enters INIT with score retained.
- Reset asserted mid-INIT and mid-PLAYING: outputs return to reset values immediately, and the INIT scan restarts at idx 0.
